amux_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the analog mux: drives its SEL bus and scans the enabled channels round-robin.
- For each channel: applies a programmable settle time, starts one ADC conversion, waits for done, then captures the result.
- Delivers (channel, data) samples to the digital side over a single-entry valid/ready output register.

---
 rtl/amux_pkg.sv | 14 +
 rtl/amux_rr_pick.sv | 35 +++
 rtl/amux_scan_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_amux_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amux_pkg.sv
// Shared definitions for the analog-mux scan controller.
package amux_pkg;

  localparam int AmuxSelWidth  = 3;
  localparam int AmuxScanMaxCh = 2 ** AmuxSelWidth;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } amux_scan_state_e;

endpackage

// File: rtl/amux_rr_pick.sv
// Round-robin channel picker: lowest enabled index strictly above last_i,
// wrapping to the lowest enabled index when none is above. wrap_o flags the wrap.
module amux_rr_pick #(
  parameter int NUM_CH = 8,
  parameter int SW     = 3
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SW-1:0]     last_i,
  output logic [SW-1:0]     next_o,
  output logic              wrap_o
);

  logic [SW-1:0] next_hi;
  logic [SW-1:0] next_lo;
  logic          found_hi;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    next_hi  = '0;
    next_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        next_lo = SW'(i);
        if (i > int'(last_i)) begin
          next_hi  = SW'(i);
          found_hi = 1'b1;
        end
      end
    end
    wrap_o = !found_hi;
    next_o = found_hi ? next_hi : next_lo;
  end

endmodule

// File: rtl/amux_scan_ctrl.sv
// Analog-mux scan sequencer: round-robin over enabled channels, settle,
// start one conversion, capture the result into a single-entry output slot.
// Build option AMUX_SCAN_TIMEOUT_EN: bounded conversion wait; a timed-out
// sample carries all-ones data and smp_err_o=1.
//
// state   | meaning
// IDLE    | waiting for en_i with a non-empty channel mask
// SETTLE  | mux select applied, counting down settle time
// CONVERT | start pulse issued, waiting for adc_done_i
// HOLD    | sample captured, waiting for the output slot to free up
module amux_scan_ctrl
  import amux_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SETTLE_W = 8,
  parameter int DATA_W   = 12,
  parameter int TO_W     = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    single_i,
  input  logic [NUM_CH-1:0]       ch_mask_i,
  input  logic [SETTLE_W-1:0]     settle_cycles_i,
  output logic [AmuxSelWidth-1:0] amux_sel_o,
  output logic                    adc_start_o,
  input  logic                    adc_done_i,
  input  logic [DATA_W-1:0]       adc_data_i,
  output logic                    smp_valid_o,
  input  logic                    smp_ready_i,
  output logic [AmuxSelWidth-1:0] smp_ch_o,
  output logic [DATA_W-1:0]       smp_data_o,
  output logic                    busy_o
`ifdef AMUX_SCAN_TIMEOUT_EN
  ,
  output logic                    smp_err_o
`endif
);

  localparam int SW = AmuxSelWidth;

  amux_scan_state_e  state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [SW-1:0]       last_q, last_d;
  logic [SW-1:0]       first_q, first_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                valid_q, valid_d;
  logic [SW-1:0]       ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SW-1:0]       hold_ch_q, hold_ch_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;

  logic [SW-1:0]       pick_idx;
  logic                pick_wrap;
  logic                pass_done;
  logic                slot_free;
  logic                got;
  logic [DATA_W-1:0]   cap_data;
  logic                load;
  logic [SW-1:0]       load_ch;
  logic [DATA_W-1:0]   load_data;

`ifdef AMUX_SCAN_TIMEOUT_EN
  logic [TO_W-1:0]     to_q, to_d;
  logic                err_q, err_d;
  logic                hold_err_q, hold_err_d;
  logic                cap_err;
  logic                load_err;
`else
  localparam int unused_to_w = TO_W;
`endif

  amux_rr_pick #(
    .NUM_CH (NUM_CH),
    .SW     (SW)
  ) u_pick (
    .mask_i (ch_mask_i),
    .last_i (last_q),
    .next_o (pick_idx),
    .wrap_o (pick_wrap)
  );

  // Pass ends when the next pick wraps back to or below the pass's first channel.
  assign pass_done = pick_wrap && (pick_idx <= first_q);
  assign slot_free = !valid_q || smp_ready_i;

  // Next-state, capture and output-slot logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    valid_d     = valid_q;
    ch_d        = ch_q;
    data_d      = data_q;
    hold_ch_d   = hold_ch_q;
    hold_data_d = hold_data_q;
    got         = 1'b0;
    cap_data    = adc_data_i;
    load        = 1'b0;
    load_ch     = hold_ch_q;
    load_data   = hold_data_q;
`ifdef AMUX_SCAN_TIMEOUT_EN
    to_d        = to_q;
    err_d       = err_q;
    hold_err_d  = hold_err_q;
    cap_err     = 1'b0;
    load_err    = hold_err_q;
`endif

    if (valid_q && smp_ready_i) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i && (ch_mask_i != '0)) begin
          sel_d   = pick_idx;
          last_d  = pick_idx;
          first_d = pick_idx;
          cnt_d   = settle_cycles_i;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          start_d = 1'b1;
          state_d = CONVERT;
`ifdef AMUX_SCAN_TIMEOUT_EN
          to_d    = '1;
`endif
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      CONVERT: begin
        // start_q marks the start cycle, where a done strobe is not trusted.
        got = !start_q && adc_done_i;
`ifdef AMUX_SCAN_TIMEOUT_EN
        if (to_q != '0) to_d = to_q - TO_W'(1);
        if (!start_q && !adc_done_i && (to_q == '0)) begin
          got      = 1'b1;
          cap_data = '1;
          cap_err  = 1'b1;
        end
`endif
        if (got) begin
          hold_ch_d   = sel_q;
          hold_data_d = cap_data;
`ifdef AMUX_SCAN_TIMEOUT_EN
          hold_err_d  = cap_err;
          load_err    = cap_err;
`endif
          if (slot_free) begin
            load      = 1'b1;
            load_ch   = sel_q;
            load_data = cap_data;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (slot_free) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      ch_d    = load_ch;
      data_d  = load_data;
`ifdef AMUX_SCAN_TIMEOUT_EN
      err_d   = load_err;
`endif
      if (en_i && (ch_mask_i != '0) && (!single_i || !pass_done)) begin
        sel_d   = pick_idx;
        last_d  = pick_idx;
        cnt_d   = settle_cycles_i;
        state_d = SETTLE;
        if (pass_done) first_d = pick_idx;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= SW'(NUM_CH - 1);
      first_q     <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      ch_q        <= '0;
      data_q      <= '0;
      hold_ch_q   <= '0;
      hold_data_q <= '0;
`ifdef AMUX_SCAN_TIMEOUT_EN
      to_q        <= '0;
      err_q       <= 1'b0;
      hold_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      hold_ch_q   <= hold_ch_d;
      hold_data_q <= hold_data_d;
`ifdef AMUX_SCAN_TIMEOUT_EN
      to_q        <= to_d;
      err_q       <= err_d;
      hold_err_q  <= hold_err_d;
`endif
    end
  end

  assign amux_sel_o  = sel_q;
  assign adc_start_o = start_q;
  assign smp_valid_o = valid_q;
  assign smp_ch_o    = ch_q;
  assign smp_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
`ifdef AMUX_SCAN_TIMEOUT_EN
  assign smp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Scoreboard bench for amux_scan_ctrl: an ADC model pushes expected samples
// when it answers a conversion, a monitor pops them on each output handshake.
module tb_amux_scan_ctrl;

  localparam int NUM_CH = 8;
  localparam int SW     = amux_pkg::AmuxSelWidth;
  localparam int DW     = 12;
  localparam int ExpRr[4] = '{0, 2, 5, 7};

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          single_i = 1'b0;
  logic [NUM_CH-1:0] ch_mask_i = '0;
  logic [7:0]    settle_cycles_i = '0;
  logic [SW-1:0] amux_sel_o;
  logic          adc_start_o;
  logic          adc_done_i;
  logic [DW-1:0] adc_data_i;
  logic          smp_valid_o;
  logic          smp_ready_i = 1'b1;
  logic [SW-1:0] smp_ch_o;
  logic [DW-1:0] smp_data_o;
  logic          busy_o;
  logic          err_bit;

  logic          auto_done = 1'b0;
  logic [DW-1:0] auto_data = '0;
  logic          man_done = 1'b0;
  logic [DW-1:0] man_data = '0;

  int            adc_mode = 1;   // 0 manual, 1 answer after adc_lat, 2 expect timeout
  int            adc_lat = 3;
  int            cd = 0;
  logic [SW-1:0] cur_ch = '0;
  int            n_starts = 0;
  int            done_cyc = 0;
  int            cyc = 0;
  int            sel_log[$];
  logic [SW+DW:0] exp_q[$];

  int            n_chk = 0;
  int            n_pass = 0;

  assign adc_done_i = auto_done | man_done;
  assign adc_data_i = man_done ? man_data : auto_data;

  amux_scan_ctrl #(
    .NUM_CH   (NUM_CH),
    .SETTLE_W (8),
    .DATA_W   (DW),
    .TO_W     (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .single_i        (single_i),
    .ch_mask_i       (ch_mask_i),
    .settle_cycles_i (settle_cycles_i),
    .amux_sel_o      (amux_sel_o),
    .adc_start_o     (adc_start_o),
    .adc_done_i      (adc_done_i),
    .adc_data_i      (adc_data_i),
    .smp_valid_o     (smp_valid_o),
    .smp_ready_i     (smp_ready_i),
    .smp_ch_o        (smp_ch_o),
    .smp_data_o      (smp_data_o),
    .busy_o          (busy_o)
`ifdef AMUX_SCAN_TIMEOUT_EN
    ,
    .smp_err_o       (err_bit)
`endif
  );

`ifndef AMUX_SCAN_TIMEOUT_EN
  assign err_bit = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ADC model: answers each start after adc_lat cycles and books the expected sample.
  always begin
    @(negedge clk);
    #1;
    auto_done = 1'b0;
    if (rst_i) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          auto_done = 1'b1;
          auto_data = 12'h5A3 + 12'(cur_ch) * 12'h111;
          exp_q.push_back({1'b0, cur_ch, auto_data});
          done_cyc = cyc;
        end
      end
      if (adc_start_o) begin
        n_starts++;
        sel_log.push_back(int'(amux_sel_o));
        if (adc_mode == 1) begin
          cd = adc_lat;
          cur_ch = amux_sel_o;
        end else if (adc_mode == 2) begin
          exp_q.push_back({1'b1, amux_sel_o, {DW{1'b1}}});
        end
      end
    end
  end

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  logic [SW+DW:0] got_v, prev_v;
  logic           prev_stall = 1'b0;
  logic [SW+DW:0] e;
  assign got_v = {err_bit, smp_ch_o, smp_data_o};

  always begin
    @(negedge clk);
    #1;
    if (smp_valid_o && smp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 32'(got_v), 32'(e));
      end
    end
    if (smp_valid_o && !smp_ready_i) begin
      if (prev_stall) chk("hold_stable", 32'(got_v), 32'(prev_v));
      prev_stall = 1'b1;
      prev_v     = got_v;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    en_i  = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int s);
    s = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_start_o) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) chk("start_seen", 32'(adc_start_o), 1);
  endtask

  task automatic wait_valid(input int budget, output int v);
    v = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (smp_valid_o) begin
        v = cyc;
        break;
      end
    end
    if (v < 0) chk("valid_seen", 32'(smp_valid_o), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    chk("idle", 32'(busy_o), 0);
  endtask

  task automatic wait_nstarts(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel_log.size() >= n) break;
    end
    chk("nstarts", 32'(sel_log.size() >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, v, b, s0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(amux_sel_o), 0);
    chk("rst_start", 32'(adc_start_o), 0);
    chk("rst_valid", 32'(smp_valid_o), 0);
    chk("rst_ch", 32'(smp_ch_o), 0);
    chk("rst_data", 32'(smp_data_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;

    // Single channel, settle 2, ADC answers 3 cycles after start
    ch_mask_i = 8'h01; settle_cycles_i = 8'd2; single_i = 1'b1; adc_lat = 3;
    @(negedge clk);
    en_i = 1'b1; c = cyc;
    @(negedge clk);
    en_i = 1'b0;
    chk("t1_sel", 32'(amux_sel_o), 0);
    chk("t1_busy", 32'(busy_o), 1);
    wait_start(30, s);
    chk("t1_start_lat", 32'(s - c), 4);
    wait_valid(30, v);
    chk("t1_valid_lat", 32'(v - done_cyc), 1);
    chk("t1_data", 32'(smp_data_o), 32'h5A3);
    wait_idle(30);

    // Round-robin single pass over 0,2,5,7
    do_reset();
    ch_mask_i = 8'hA5; settle_cycles_i = 8'd1; single_i = 1'b1; adc_lat = 2;
    b = sel_log.size();
    en_i = 1'b1;
    wait_idle(300);
    en_i = 1'b0;
    chk("rr_count", 32'(sel_log.size() - b), 4);
    for (int i = 0; i < 4; i++)
      if (b + i < sel_log.size()) chk("rr_sel", 32'(sel_log[b+i]), 32'(ExpRr[i]));

    // Continuous mode wraps 7 -> 0
    b = sel_log.size();
    single_i = 1'b0;
    en_i = 1'b1;
    wait_nstarts(b + 5, 400);
    en_i = 1'b0;
    if (sel_log.size() >= b + 5) begin
      chk("cont_sel3", 32'(sel_log[b+3]), 7);
      chk("cont_wrap", 32'(sel_log[b+4]), 0);
    end
    wait_idle(100);

    // Backpressure: two conversions, second held, no third start
    do_reset();
    ch_mask_i = 8'h03; settle_cycles_i = 8'd1; single_i = 1'b0; adc_lat = 2;
    smp_ready_i = 1'b0;
    s0 = n_starts;
    en_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_starts", 32'(n_starts - s0), 2);
    chk("bp_valid", 32'(smp_valid_o), 1);
    chk("bp_ch", 32'(smp_ch_o), 0);
    chk("bp_data", 32'(smp_data_o), 32'h5A3);
    chk("bp_busy", 32'(busy_o), 1);
    chk("bp_pending", 32'(exp_q.size()), 2);
    smp_ready_i = 1'b1;
    en_i = 1'b0;
    wait_idle(50);
    repeat (3) @(negedge clk);
    chk("bp_drained", 32'(exp_q.size()), 0);
    chk("bp_starts_end", 32'(n_starts - s0), 2);

    // Zero settle, then zero mask
    do_reset();
    ch_mask_i = 8'h01; settle_cycles_i = 8'd0; single_i = 1'b1; adc_lat = 2;
    en_i = 1'b1; c = cyc;
    @(negedge clk);
    en_i = 1'b0;
    wait_start(20, s);
    chk("zs_start_lat", 32'(s - c), 2);
    wait_idle(50);
    ch_mask_i = '0;
    s0 = n_starts;
    en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("zm_busy", 32'(busy_o), 0);
    end
    chk("zm_starts", 32'(n_starts - s0), 0);
    en_i = 1'b0;

    // Reset during CONVERT with done in the reset cycle
    do_reset();
    ch_mask_i = 8'h06; settle_cycles_i = 8'd1; single_i = 1'b0; adc_mode = 0;
    en_i = 1'b1;
    wait_start(20, s);
    chk("rc_sel", 32'(amux_sel_o), 1);
    @(negedge clk);
    rst_i = 1'b1; en_i = 1'b0; man_done = 1'b1; man_data = 12'hABC; ch_mask_i = 8'h07;
    @(negedge clk);
    rst_i = 1'b0; man_done = 1'b0;
    chk("rc_sel0", 32'(amux_sel_o), 0);
    chk("rc_start0", 32'(adc_start_o), 0);
    chk("rc_valid0", 32'(smp_valid_o), 0);
    chk("rc_ch0", 32'(smp_ch_o), 0);
    chk("rc_data0", 32'(smp_data_o), 0);
    chk("rc_busy0", 32'(busy_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rc_no_sample", 32'(smp_valid_o), 0);
    end
    adc_mode = 1; adc_lat = 2; single_i = 1'b1;
    en_i = 1'b1;
    wait_start(20, s);
    chk("rc_restart_ch0", 32'(amux_sel_o), 0);
    en_i = 1'b0;
    wait_idle(50);
    repeat (3) @(negedge clk);

`ifdef AMUX_SCAN_TIMEOUT_EN
    // Timeout: no done, sample with all-ones and error, scan advances
    do_reset();
    ch_mask_i = 8'h03; settle_cycles_i = 8'd1; single_i = 1'b1; adc_mode = 2;
    en_i = 1'b1;
    wait_start(20, s);
    wait_valid(40, v);
    chk("to_lat", 32'(v - s), 16);
    chk("to_err", 32'(err_bit), 1);
    chk("to_data", 32'(smp_data_o), 32'hFFF);
    wait_start(40, s);
    chk("to_next_ch", 32'(amux_sel_o), 1);
    en_i = 1'b0;
    wait_idle(60);
    repeat (3) @(negedge clk);
    adc_mode = 1;
`endif

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
